// File: rtl/prbs_pattern_source.sv
// PRBS pattern source: PRBS7/15/23/31 LFSR emitting one WIDTH-bit word per cycle on a valid/ready stream.
// Latency: first word valid 2 cycles after enable_in rises, then back-to-back one word per accepted beat.
// Backpressure: m_tready low holds m_tdata/m_tvalid stable; the LFSR only advances when a word is registered.
module prbs_pattern_source #(
  parameter int          WIDTH = 32,
  parameter logic [30:0] SEED  = 31'h7FFFFFFF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable_in,
  input  logic [1:0]       mode_in,
  input  logic [30:0]      seed_in,
  input  logic             load_in,
  input  logic             invert_in,
  input  logic             err_inject_in,
  output logic [WIDTH-1:0] m_tdata,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic             busy_out,
  output logic [31:0]      word_cnt_out
);

  typedef enum logic [1:0] {IDLE, FILL, RUN, DRAIN} state_t;

  state_t      state, state_nxt;
  logic [30:0] lfsr;
  logic [1:0]  mode_q;
  logic        err_pend;

  logic [WIDTH-1:0] gen_word;
  logic [30:0]      gen_next;

  logic do_load_seed, do_latch_mode, do_gen, do_accept, do_clear_valid;

  // Bits at and above the polynomial order must stay zero.
  function automatic logic [30:0] order_mask(input logic [1:0] m);
    case (m)
      2'd0:    order_mask = 31'h0000007F;
      2'd1:    order_mask = 31'h00007FFF;
      2'd2:    order_mask = 31'h007FFFFF;
      default: order_mask = 31'h7FFFFFFF;
    endcase
  endfunction

  // An all-zero LFSR never leaves zero, so a zero seed is replaced by 1.
  function automatic logic [30:0] guard_seed(input logic [30:0] v, input logic [1:0] m);
    logic [30:0] masked;
    masked = v & order_mask(m);
    guard_seed = (masked == 31'd0) ? 31'd1 : masked;
  endfunction

  // Unroll WIDTH Fibonacci steps; the first generated bit lands in the MSB.
  always_comb begin
    logic [30:0] s;
    logic        fb;
    s        = lfsr;
    fb       = 1'b0;
    gen_word = '0;
    for (int i = 0; i < WIDTH; i++) begin
      case (mode_q)
        2'd0:    fb = s[6]  ^ s[5];
        2'd1:    fb = s[14] ^ s[13];
        2'd2:    fb = s[22] ^ s[17];
        default: fb = s[30] ^ s[27];
      endcase
      s = {s[29:0], fb} & order_mask(mode_q);
      gen_word[WIDTH-1-i] = fb;
    end
    gen_next = s;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and datapath control strobes.
  always_comb begin
    state_nxt      = state;
    do_load_seed   = 1'b0;
    do_latch_mode  = 1'b0;
    do_gen         = 1'b0;
    do_accept      = 1'b0;
    do_clear_valid = 1'b0;
    case (state)
      IDLE: begin
        do_load_seed = load_in;
        if (enable_in) begin
          do_latch_mode = 1'b1;
          state_nxt     = FILL;
        end
      end
      FILL: begin
        do_gen    = 1'b1;
        state_nxt = RUN;
      end
      RUN: begin
        if (m_tvalid && m_tready) begin
          do_accept = 1'b1;
          if (enable_in) begin
            do_gen = 1'b1;
          end else begin
            // Last word taken on the same beat enable fell: nothing left to drain.
            do_clear_valid = 1'b1;
            state_nxt      = IDLE;
          end
        end else if (!enable_in) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (m_tvalid && m_tready) begin
          do_accept      = 1'b1;
          do_clear_valid = 1'b1;
          state_nxt      = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // LFSR, latched mode, output word, error flag and accepted-word counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr         <= guard_seed(SEED, 2'd3);
      mode_q       <= 2'd3;
      m_tdata      <= '0;
      m_tvalid     <= 1'b0;
      err_pend     <= 1'b0;
      word_cnt_out <= 32'd0;
    end else begin
      if (do_load_seed)      lfsr <= guard_seed(seed_in, mode_in);
      else if (do_gen)       lfsr <= gen_next;
      if (do_latch_mode)     mode_q <= mode_in;
      if (do_gen) begin
        m_tdata  <= gen_word ^ {WIDTH{invert_in}} ^ {{(WIDTH-1){1'b0}}, err_pend};
        m_tvalid <= 1'b1;
      end else if (do_clear_valid) begin
        m_tvalid <= 1'b0;
      end
      // A word registered this edge consumes the pending flag; a new request re-arms it.
      err_pend <= (err_pend & ~do_gen) | err_inject_in;
      if (do_accept)         word_cnt_out <= word_cnt_out + 32'd1;
    end
  end

  assign busy_out = (state != IDLE);

endmodule

// File: tb/tb_prbs_pattern_source.sv
// Bench for prbs_pattern_source at WIDTH=8: directed PRBS7 vector table plus
// hand sequences for seed guard, random stalls, drain and reset mid-drain.
module tb_prbs_pattern_source;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable_in;
  logic [1:0]  mode_in;
  logic [30:0] seed_in;
  logic        load_in;
  logic        invert_in;
  logic        err_inject_in;
  logic [7:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        busy_out;
  logic [31:0] word_cnt_out;

  int n_checks = 0;
  int n_pass   = 0;

  prbs_pattern_source #(.WIDTH(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .enable_in     (enable_in),
    .mode_in       (mode_in),
    .seed_in       (seed_in),
    .load_in       (load_in),
    .invert_in     (invert_in),
    .err_inject_in (err_inject_in),
    .m_tdata       (m_tdata),
    .m_tvalid      (m_tvalid),
    .m_tready      (m_tready),
    .busy_out      (busy_out),
    .word_cnt_out  (word_cnt_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        load;
    logic        en;
    logic        rdy;
    logic        inv;
    logic        err;
    logic [1:0]  mode;
    logic [30:0] seed;
    logic        exp_valid;
    logic [7:0]  exp_data;
    logic        exp_busy;
    logic [31:0] exp_cnt;
  } vec_t;

  vec_t tbl [19];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference PRBS: one 8-bit word of Fibonacci steps, first bit in the MSB.
  function automatic void model_word(input logic [30:0] st_in, input logic [1:0] md,
                                     output logic [7:0] w, output logic [30:0] st_out);
    logic [30:0] s;
    logic        b;
    int          n;
    n = (md == 2'd0) ? 7 : (md == 2'd1) ? 15 : (md == 2'd2) ? 23 : 31;
    s = st_in;
    w = 8'h00;
    for (int i = 0; i < 8; i++) begin
      case (md)
        2'd0:    b = s[6]  ^ s[5];
        2'd1:    b = s[14] ^ s[13];
        2'd2:    b = s[22] ^ s[17];
        default: b = s[30] ^ s[27];
      endcase
      s = {s[29:0], b};
      for (int k = 0; k < 31; k++) if (k >= n) s[k] = 1'b0;
      w = {w[6:0], b};
    end
    st_out = s;
  endfunction

  task automatic idle_inputs();
    enable_in = 0; mode_in = 0; seed_in = 0; load_in = 0;
    invert_in = 0; err_inject_in = 0; m_tready = 0;
  endtask

  initial begin
    logic [30:0] mst;
    logic [7:0]  mw;
    logic [7:0]  held;
    logic        was_rdy;
    int          acc;

    // PRBS7 from seed 7F: words 02 0C 28 F2 2C EA 7D (hand-derived).
    //         load en rdy inv err mode seed      vld data  busy cnt
    tbl[0]  = '{1, 0, 1, 0, 0, 2'd0, 31'h7F,  0, 8'h00, 0, 0};
    tbl[1]  = '{0, 1, 1, 0, 0, 2'd0, 31'h00,  0, 8'h00, 1, 0};
    tbl[2]  = '{1, 1, 1, 0, 0, 2'd3, 31'h00,  1, 8'h02, 1, 0};
    tbl[3]  = '{0, 1, 1, 0, 0, 2'd0, 31'h00,  1, 8'h0C, 1, 1};
    tbl[4]  = '{0, 1, 0, 0, 0, 2'd0, 31'h00,  1, 8'h0C, 1, 1};
    tbl[5]  = '{0, 1, 0, 1, 0, 2'd0, 31'h00,  1, 8'h0C, 1, 1};
    tbl[6]  = '{0, 1, 1, 1, 0, 2'd0, 31'h00,  1, 8'hD7, 1, 2};
    tbl[7]  = '{0, 1, 1, 0, 0, 2'd0, 31'h00,  1, 8'hF2, 1, 3};
    tbl[8]  = '{0, 0, 0, 0, 0, 2'd0, 31'h00,  1, 8'hF2, 1, 3};
    tbl[9]  = '{1, 1, 0, 0, 0, 2'd0, 31'h00,  1, 8'hF2, 1, 3};
    tbl[10] = '{0, 1, 1, 0, 0, 2'd0, 31'h00,  0, 8'hF2, 0, 4};
    tbl[11] = '{0, 0, 1, 0, 0, 2'd0, 31'h00,  0, 8'hF2, 0, 4};
    tbl[12] = '{0, 1, 0, 0, 0, 2'd0, 31'h00,  0, 8'hF2, 1, 4};
    tbl[13] = '{0, 1, 0, 0, 1, 2'd0, 31'h00,  1, 8'h2C, 1, 4};
    tbl[14] = '{0, 1, 0, 0, 1, 2'd0, 31'h00,  1, 8'h2C, 1, 4};
    tbl[15] = '{0, 1, 1, 0, 0, 2'd0, 31'h00,  1, 8'hEB, 1, 5};
    tbl[16] = '{0, 1, 1, 0, 0, 2'd0, 31'h00,  1, 8'h7D, 1, 6};
    tbl[17] = '{0, 0, 0, 0, 0, 2'd0, 31'h00,  1, 8'h7D, 1, 6};
    tbl[18] = '{0, 0, 1, 0, 0, 2'd0, 31'h00,  0, 8'h7D, 0, 7};

    idle_inputs();
    reset = 1;
    tick(); tick();
    check("rst_valid", {31'd0, m_tvalid}, 32'd0);
    check("rst_data",  {24'd0, m_tdata},  32'd0);
    check("rst_busy",  {31'd0, busy_out}, 32'd0);
    check("rst_cnt",   word_cnt_out,      32'd0);
    reset = 0;

    for (int r = 0; r < 19; r++) begin
      load_in = tbl[r].load; enable_in = tbl[r].en; m_tready = tbl[r].rdy;
      invert_in = tbl[r].inv; err_inject_in = tbl[r].err;
      mode_in = tbl[r].mode; seed_in = tbl[r].seed;
      tick();
      check($sformatf("tbl%0d_valid", r), {31'd0, m_tvalid}, {31'd0, tbl[r].exp_valid});
      check($sformatf("tbl%0d_data",  r), {24'd0, m_tdata},  {24'd0, tbl[r].exp_data});
      check($sformatf("tbl%0d_busy",  r), {31'd0, busy_out}, {31'd0, tbl[r].exp_busy});
      check($sformatf("tbl%0d_cnt",   r), word_cnt_out,      tbl[r].exp_cnt);
    end
    idle_inputs();

    // Zero seed in PRBS15 with load+enable together: guarded to 1, words 00 then 06.
    reset = 1; tick(); reset = 0;
    load_in = 1; enable_in = 1; mode_in = 2'd1; seed_in = 31'd0;
    tick();
    load_in = 0; mode_in = 2'd2;
    tick();
    check("p15_first_valid", {31'd0, m_tvalid}, 32'd1);
    check("p15_first_data",  {24'd0, m_tdata},  32'h00);
    m_tready = 1;
    tick();
    check("p15_second_data", {24'd0, m_tdata},  32'h06);
    check("p15_second_cnt",  word_cnt_out,      32'd1);
    mst = 31'd1;
    model_word(mst, 2'd1, mw, mst);
    model_word(mst, 2'd1, mw, mst);
    acc = 1;

    // Random backpressure against the reference model.
    for (int c = 0; c < 200; c++) begin
      held     = m_tdata;
      was_rdy  = 1'($urandom_range(0, 1));
      m_tready = was_rdy;
      tick();
      if (was_rdy) begin
        acc++;
        model_word(mst, 2'd1, mw, mst);
        check("rand_next_word", {24'd0, m_tdata}, {24'd0, mw});
      end else begin
        check("rand_stall_hold", {24'd0, m_tdata}, {24'd0, held});
      end
      check("rand_valid", {31'd0, m_tvalid}, 32'd1);
    end
    check("rand_cnt", word_cnt_out, acc);

    // Enable dropped while stalled: word held through DRAIN, then released.
    held = m_tdata;
    m_tready = 0; enable_in = 0;
    tick(); tick();
    check("drain_hold_data",  {24'd0, m_tdata},  {24'd0, held});
    check("drain_hold_valid", {31'd0, m_tvalid}, 32'd1);
    check("drain_hold_busy",  {31'd0, busy_out}, 32'd1);
    m_tready = 1;
    tick();
    check("drain_done_valid", {31'd0, m_tvalid}, 32'd0);
    check("drain_done_busy",  {31'd0, busy_out}, 32'd0);
    check("drain_done_cnt",   word_cnt_out,      acc + 1);
    tick();
    check("drain_no_extra",   {31'd0, m_tvalid}, 32'd0);

    // PRBS31 from the default seed, then reset while a word is held in DRAIN.
    idle_inputs();
    reset = 1; tick(); reset = 0;
    enable_in = 1; mode_in = 2'd3;
    tick(); tick();
    mst = 31'h7FFFFFFF;
    model_word(mst, 2'd3, mw, mst);
    check("p31_first_data", {24'd0, m_tdata}, {24'd0, mw});
    m_tready = 1;
    tick();
    model_word(mst, 2'd3, mw, mst);
    check("p31_second_data", {24'd0, m_tdata}, {24'd0, mw});
    m_tready = 0; enable_in = 0;
    tick();
    check("pre_rst_busy",  {31'd0, busy_out}, 32'd1);
    check("pre_rst_valid", {31'd0, m_tvalid}, 32'd1);
    reset = 1; m_tready = 1; enable_in = 1;
    tick();
    check("mid_drain_rst_valid", {31'd0, m_tvalid}, 32'd0);
    check("mid_drain_rst_cnt",   word_cnt_out,      32'd0);
    check("mid_drain_rst_busy",  {31'd0, busy_out}, 32'd0);
    check("mid_drain_rst_data",  {24'd0, m_tdata},  32'd0);
    reset = 0; enable_in = 0;
    tick();
    check("post_rst_idle", {31'd0, busy_out}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/prbs_pattern_source.md
PRBS_PATTERN_SOURCE -- requirements
Module: prbs_pattern_source

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, meaning output word width in bits; legal range 8..64.
REQ-002 The module SHALL have parameter SEED, default 31'h7FFFFFFF, meaning the LFSR state loaded at reset.
REQ-003 The module SHALL have port clk  input  1  rising-edge clock.
REQ-004 The module SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The module SHALL have port enable_in  input  1  run request; high starts or continues generation.
REQ-006 The module SHALL have port mode_in  input  2  polynomial select: 0=PRBS7 (x^7+x^6+1), 1=PRBS15 (x^15+x^14+1), 2=PRBS23 (x^23+x^18+1), 3=PRBS31 (x^31+x^28+1).
REQ-007 The module SHALL have port seed_in  input  31  seed value, low N bits used for order N.
REQ-008 The module SHALL have port load_in  input  1  single-cycle seed load strobe.
REQ-009 The module SHALL have port invert_in  input  1  invert every output bit when high.
REQ-010 The module SHALL have port err_inject_in  input  1  single-cycle request to corrupt one word.
REQ-011 The module SHALL have port m_tdata  output  WIDTH  pattern word.
REQ-012 The module SHALL have port m_tvalid  output  1  m_tdata valid.
REQ-013 The module SHALL have port m_tready  input  1  downstream accept.
REQ-014 The module SHALL have port busy_out  output  1  high in any state other than IDLE.
REQ-015 The module SHALL have port word_cnt_out  output  32  count of accepted words, wraps 2^32-1 -> 0.

Function
REQ-016 The LFSR SHALL be a 31-bit Fibonacci register; one bit step is new = s[T1]^s[T2], s = {s[29:0], new}, with bits at and above order N forced to 0; taps (T1,T2) are (6,5), (14,13), (22,17), (30,27) for mode 0..3.
REQ-017 Each word SHALL be WIDTH consecutive bit steps computed in one cycle; the first generated bit SHALL be m_tdata[WIDTH-1] and the last m_tdata[0].
REQ-018 The state machine SHALL have states IDLE, FILL, RUN, DRAIN.
REQ-019 In IDLE, enable_in=1 SHALL latch mode_in and move to FILL; mode_in changes outside IDLE SHALL be ignored.
REQ-020 FILL SHALL compute the first word into m_tdata, advance the LFSR by WIDTH steps and enter RUN with m_tvalid=1 on the next cycle (first valid 2 cycles after enable_in rises).
REQ-021 In RUN, on m_tvalid&m_tready the next word SHALL replace m_tdata in the same edge (back-to-back, one word per cycle), and word_cnt_out SHALL increment.
REQ-022 While m_tvalid=1 and m_tready=0, m_tdata and m_tvalid SHALL be held stable.
REQ-023 enable_in=0 in RUN SHALL go to DRAIN; DRAIN SHALL hold the current word until accepted, then clear m_tvalid and go to IDLE without generating a further word.
REQ-024 enable_in returning to 1 during DRAIN SHALL be ignored until IDLE is reached.
REQ-025 load_in SHALL be accepted only in IDLE: LFSR <= seed_in masked to order N of the mode_in value present at that cycle; load_in in other states SHALL be ignored.
REQ-026 A seed masking to all-zero SHALL load 1 instead (lock-up guard); the same guard SHALL apply to SEED at reset.
REQ-027 invert_in SHALL XOR m_tdata with all ones when the word is registered; the LFSR SHALL be unaffected.
REQ-028 err_inject_in SHALL set a pending flag; the next word registered after the flag is set SHALL have bit 0 flipped and clear the flag; multiple requests before that word SHALL collapse to one; LFSR SHALL be unaffected.
REQ-029 load_in and enable_in together in IDLE SHALL load first, then FILL from the loaded seed.

Reset
REQ-030 reset SHALL force IDLE, m_tvalid=0, m_tdata=0, busy_out=0, word_cnt_out=0, error flag clear, LFSR=SEED (guarded), latched mode=3.
REQ-031 reset SHALL override all other inputs in any state, including mid-DRAIN with a word held.

Verification
REQ-032 WIDTH=8, mode 0, load seed 7'h7F, enable, m_tready=1 -> first word 8'h02, LFSR state 7'h02 afterwards.
REQ-033 Mode 3 default seed, m_tready=1 for 2^31-1 bit steps equivalent -> sequence repeats, bit-exact against software model, no all-zero word run exceeding 30 bits.
REQ-034 RUN with m_tready toggled randomly -> m_tdata stable while stalled, no word dropped or duplicated against model, word_cnt_out equals accepted count.
REQ-035 err_inject_in pulsed twice while stalled -> exactly one later word differs from model, only in bit 0; following words match model.
REQ-036 Load seed 0 in mode 1 -> LFSR=1, generation proceeds; enable dropped while stalled -> word held, accepted, then m_tvalid=0, busy_out=0.
REQ-037 reset asserted mid-DRAIN -> next cycle m_tvalid=0, word_cnt_out=0, state IDLE.
